// File: rtl/fx3_pll_reset_sequencer.sv
// Sequences the FX3 interface PLL reset, qualifies its lock output and
// releases the FX3-domain reset once lock has been stable long enough.
`timescale 1ns/1ps
module fx3_pll_reset_sequencer #(
    parameter int unsigned RESET_HOLD_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_WIDTH           = 20
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       fx3_reset,
    output logic       ready,
    output logic [7:0] timeout_count,
    output logic [7:0] lol_count
);

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [7:0]           COUNT_MAX    = 8'hFF;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 sync_q;
    logic                 locked_s;
    logic                 restart;
    logic                 timeout_evt;
    logic                 lol_evt;

    // Next-state decode; force_relock overrides every other transition.
    always_comb begin
        state_nxt   = state;
        timeout_evt = 1'b0;
        lol_evt     = 1'b0;
        if (force_relock) begin
            state_nxt = HOLD;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_nxt   = HOLD;
                        timeout_evt = 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s)                state_nxt = WAIT_LOCK;
                    else if (cnt == STABLE_LAST)  state_nxt = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        state_nxt = HOLD;
                        lol_evt   = 1'b1;
                    end
                end
                default: state_nxt = HOLD;
            endcase
        end
        // A forced relock in HOLD counts as re-entry so the hold window restarts.
        restart = force_relock || (state_nxt != state);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q        <= 1'b0;
            locked_s      <= 1'b0;
            state         <= HOLD;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            fx3_reset     <= 1'b1;
            ready         <= 1'b0;
            timeout_count <= 8'd0;
            lol_count     <= 8'd0;
        end else begin
            sync_q    <= pll_locked;
            locked_s  <= sync_q;
            state     <= state_nxt;
            cnt       <= restart ? '0 : cnt + CNT_WIDTH'(1);
            pll_rst   <= (state_nxt == HOLD);
            fx3_reset <= (state_nxt != RUN);
            ready     <= (state_nxt == RUN);
            if (timeout_evt && (timeout_count != COUNT_MAX)) timeout_count <= timeout_count + 8'd1;
            if (lol_evt && (lol_count != COUNT_MAX))         lol_count     <= lol_count + 8'd1;
        end
    end

endmodule
